// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop input synchronizer and centre sampling.
// One-entry holding register with valid/ready handshake and overrun/frame flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            busy_q, busy_d;
  logic            rxs, load, consume, take;

  assign rxs = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rxs) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A consume on the stop-sample edge frees the slot for the new byte.
  always_comb begin
    consume = valid_q & rx_ready;
    take    = load & (~valid_q | consume);
    valid_d = (valid_q & ~consume) | take;
    data_d  = take ? shift_q : data_q;
    ovr_d   = (load & valid_q & ~consume) | (ovr_q & ~err_clr);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT = 8.
// Expected bytes go into a queue at send time and are popped on handshake.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  uart_rx #(.CLKS_PER_BIT(8)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rx_ready(rx_ready), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int rise_cyc = 0;
  int vcnt = 0;
  int vlow = 0;
  int fcnt = 0;
  logic pv = 1'b0;
  logic [7:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      pv = 1'b0;
    end else begin
      if (rx_valid) vcnt++;
      else vlow++;
      if (rx_valid && !pv) rise_cyc = cyc;
      pv = rx_valid;
      if (frame_err) fcnt++;
      if (rx_valid && rx_ready) begin
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) chk("rx_data", rx_data, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1 rx = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (8) @(posedge clk);
    #1 rx = stop_bit;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    #1 reset = 1'b1;

    // 1: single byte, latency and one-cycle valid
    rx_ready = 1'b1;
    vcnt = 0;
    fcnt = 0;
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    lat = rise_cyc - c0;
    chk("latency_ok", (lat >= 78 && lat <= 80), 1);
    chk("valid_cycles", vcnt, 1);
    chk("t1_ferr", fcnt, 0);
    chk("t1_ovr", overrun, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: overrun with back-to-back frames
    rx_ready = 1'b0;
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t2_ovr", overrun, 1);
    chk("t2_valid", rx_valid, 1);
    chk("t2_data", rx_data, 8'h3C);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t2_ovr_clr", overrun, 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("t2_valid_drop", rx_valid, 0);
    chk("t2_sb_empty", sb.size(), 0);

    // 3: framing error then break
    fcnt = 0;
    vcnt = 0;
    send(8'h55, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t3_ferr_pulse", fcnt, 1);
    chk("t3_busy_break", busy, 1);
    chk("t3_valid", rx_valid, 0);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t3_busy_idle", busy, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("t3_no_spurious", vcnt, 0);

    // 4: start glitch rejected
    fcnt = 0;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_busy_seen", busy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_busy_back", busy, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t4_valid", rx_valid, 0);
    chk("t4_ferr", fcnt, 0);

    // 5: consume and load on the same edge
    rx_ready = 1'b0;
    sb.push_back(8'h11);
    send(8'h11, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_held", rx_valid, 1);
    vlow = 0;
    sb.push_back(8'h81);
    fork
      send(8'h81, 1'b1);
      begin
        @(posedge clk);
        repeat (78) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("t5_valid_gap", vlow, 0);
    chk("t5_data", rx_data, 8'h81);
    chk("t5_ovr", overrun, 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("t5_valid_drop", rx_valid, 0);
    chk("t5_sb_empty", sb.size(), 0);

    // 6: asynchronous reset mid-frame
    sb.push_back(8'h77);
    send(8'h77, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_held", rx_data, 8'h77);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_data", rx_data, 8'h00);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovr", overrun, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_valid", rx_valid, 0);
    rx_ready = 1'b1;
    sb.push_back(8'h01);
    send(8'h01, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_valid_end", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
